// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one in-order signed multiplier among NumReq requesters.
// Define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mul_arbiter #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned NumReq    = 3,
  parameter int unsigned TagDepth  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_a_i,
  input  logic [NumReq*DataWidth-1:0] req_b_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        mul_valid_o,
  output logic [DataWidth-1:0]        mul_a_o,
  output logic [DataWidth-1:0]        mul_b_o,
  input  logic                        mul_ready_i,
  input  logic                        mul_valid_i,
  input  logic [2*DataWidth-1:0]      mul_c_i,
  output logic                        mul_ready_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [2*DataWidth-1:0]      rsp_c_o,
  input  logic [NumReq-1:0]           rsp_ready_i
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned AddrW = $clog2(TagDepth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [IdxW-1:0] tag_q [TagDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            full, empty;
  logic [IdxW-1:0] head;

  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;

  logic            cand_vld;
  logic [IdxW-1:0] cand_idx;
  logic            grant_vld;
  logic [IdxW-1:0] grant_idx;
  logic            issue;
  logic            pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign head  = tag_q[rd_ptr_q[AddrW-1:0]];

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!cand_vld && req_valid_i[i]) begin
        cand_vld = 1'b1;
        cand_idx = IdxW'(i);
      end
    end
  end
`else
  localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW:0]   scan;

  // Scan upward from rr_ptr_q with wrap; first valid requester wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    scan     = '0;
    for (int i = 0; i < NumReq; i++) begin
      scan = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (scan >= NumReqW) scan = scan - NumReqW;
      if (!cand_vld && req_valid_i[scan[IdxW-1:0]]) begin
        cand_vld = 1'b1;
        cand_idx = scan[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else if (issue) begin
      rr_ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // A stalled offer keeps its requester until the multiplier takes it.
  assign grant_idx = lock_q ? lock_idx_q : cand_idx;
  assign grant_vld = lock_q ? req_valid_i[lock_idx_q] : cand_vld;

  always_comb begin
    mul_valid_o = !reset_i && grant_vld && !full;
    issue       = mul_valid_o && mul_ready_i;
    req_ready_o = '0;
    if (issue) req_ready_o[grant_idx] = 1'b1;
    mul_a_o = '0;
    mul_b_o = '0;
    if (mul_valid_o) begin
      mul_a_o = req_a_i[grant_idx*DataWidth +: DataWidth];
      mul_b_o = req_b_i[grant_idx*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (!reset_i && mul_valid_i && !empty) rsp_valid_o[head] = 1'b1;
    mul_ready_o = !reset_i && !empty && rsp_ready_i[head];
    pop         = mul_valid_i && mul_ready_o;
    rsp_c_o     = reset_i ? '0 : mul_c_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (issue) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (issue) begin
        lock_q <= 1'b0;
      end else if (mul_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) tag_q[wr_ptr_q[AddrW-1:0]] <= grant_idx;
  end

`ifndef SYNTHESIS
  // A product with no outstanding tag means the multiplier was not flushed with us.
  a_no_orphan_product: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mul_valid_i && empty))
    else $error("mul_arbiter: product returned with empty tag FIFO");
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: multiplier model with programmable latency/hold,
// scoreboard of expected (requester, product) pairs checked on every return handshake.
module tb_mul_arbiter;

  localparam int DW = 16;
  localparam int NR = 3;
  localparam int TD = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR*DW-1:0]  req_a_i, req_b_i;
  logic [NR-1:0]     req_ready_o;
  logic              mul_valid_o;
  logic [DW-1:0]     mul_a_o, mul_b_o;
  logic              mul_ready_i = 1'b1;
  logic              mul_valid_i = 1'b0;
  logic [2*DW-1:0]   mul_c_i = '0;
  logic              mul_ready_o;
  logic [NR-1:0]     rsp_valid_o;
  logic [2*DW-1:0]   rsp_c_o;
  logic [NR-1:0]     rsp_ready_i = '1;

  logic signed [DW-1:0] tb_a [NR];
  logic signed [DW-1:0] tb_b [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_a_i[g*DW +: DW] = tb_a[g];
    assign req_b_i[g*DW +: DW] = tb_b[g];
  end

  mul_arbiter #(.DataWidth(DW), .NumReq(NR), .TagDepth(TD)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_ready_o (req_ready_o),
    .mul_valid_o (mul_valid_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_ready_i (mul_ready_i),
    .mul_valid_i (mul_valid_i),
    .mul_c_i     (mul_c_i),
    .mul_ready_o (mul_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_c_o     (rsp_c_o),
    .rsp_ready_i (rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int                     idx;
    logic signed [2*DW-1:0] c;
  } exp_t;

  typedef struct {
    logic [2*DW-1:0] c;
    int              rdy;
  } pipe_t;

  exp_t  exp_q[$];
  pipe_t pipe_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int mul_lat  = 2;
  bit mul_hold = 1'b0;
  int mcyc     = 0;

  bit              issue_s, ret_s, rst_s;
  logic [2*DW-1:0] prod_s;

  // Monitor: sample handshakes mid-cycle, push expectations on issue, check on return.
  always @(negedge clk_i) begin
    exp_t e;
    int   k;
    rst_s   = reset_i;
    issue_s = mul_valid_o && mul_ready_i;
    ret_s   = mul_valid_i && mul_ready_o;
    prod_s  = $signed(mul_a_o) * $signed(mul_b_o);
    if (rst_s) exp_q.delete();
    if (issue_s) begin
      n_checks++;
      if ($countones(req_ready_o) != 1)
        $display("FAIL issue_onehot: req_ready_o=%b want exactly one bit", req_ready_o);
      else n_pass++;
      k = -1;
      for (int i = 0; i < NR; i++) if (req_ready_o[i]) k = i;
      if (k >= 0) begin
        e.idx = k;
        e.c   = tb_a[k] * tb_b[k];
        exp_q.push_back(e);
      end
    end
    if (ret_s) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL ret_unexpected: rsp_valid_o=%b rsp_c_o=%h want no return", rsp_valid_o,
                 rsp_c_o);
      end else begin
        e = exp_q.pop_front();
        if (rsp_valid_o !== NR'(1 << e.idx) || rsp_c_o !== e.c)
          $display("FAIL ret_route: rsp_valid_o=%b rsp_c_o=%h want %b %h", rsp_valid_o, rsp_c_o,
                   NR'(1 << e.idx), e.c);
        else n_pass++;
      end
    end
  end

  // Multiplier model: in-order pipe of mul_lat cycles, stallable via mul_hold.
  always @(posedge clk_i) begin
    #2;
    mcyc++;
    if (rst_s) begin
      pipe_q.delete();
    end else begin
      if (ret_s && pipe_q.size() > 0) void'(pipe_q.pop_front());
      if (issue_s) pipe_q.push_back('{c: prod_s, rdy: mcyc + mul_lat - 1});
    end
    mul_valid_i = 1'b0;
    mul_c_i     = '0;
    if (pipe_q.size() > 0) begin
      mul_c_i     = pipe_q[0].c;
      mul_valid_i = !mul_hold && (mcyc >= pipe_q[0].rdy);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    reset_i     = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic set_rr_ops();
    tb_a[0] = 16'sd3;     tb_b[0] = -16'sd4;
    tb_a[1] = 16'sd100;   tb_b[1] = 16'sd7;
    tb_a[2] = -16'sd32768; tb_b[2] = -16'sd32768;
  endtask

  task automatic drain();
    mul_hold    = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = '1;
    mul_ready_i = 1'b1;
    for (int i = 0; i < 40 && (exp_q.size() > 0 || pipe_q.size() > 0); i++) tick();
    @(negedge clk_i);
    n_checks++;
    if (exp_q.size() != 0 || pipe_q.size() != 0)
      $display("FAIL drain: %0d expected returns outstanding, want 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (mul_ready_o !== 1'b0)
      $display("FAIL drain_empty: mul_ready_o=%b want 0", mul_ready_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    set_rr_ops();
    reset_i     = 1'b1;
    req_valid_i = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_checks++;
      if ({mul_valid_o, req_ready_o, mul_ready_o, rsp_valid_o} !== '0)
        $display("FAIL reset_ctrl: valid=%b ready=%b mready=%b rsp=%b want all 0", mul_valid_o,
                 req_ready_o, mul_ready_o, rsp_valid_o);
      else n_pass++;
      n_checks++;
      if ({mul_a_o, mul_b_o, rsp_c_o} !== '0)
        $display("FAIL reset_bus: a=%h b=%h c=%h want 0", mul_a_o, mul_b_o, rsp_c_o);
      else n_pass++;
      tick();
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (req_ready_o !== 3'b001 || mul_valid_o !== 1'b1)
      $display("FAIL reset_first_grant: req_ready_o=%b mul_valid_o=%b want 001 1", req_ready_o,
               mul_valid_o);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] oh;
    set_rr_ops();
    mul_lat = 2;
    do_reset();
    req_valid_i = '1;
    for (int c = 0; c < 6; c++) begin
      oh = '0;
      oh[c % NR] = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (req_ready_o !== oh)
        $display("FAIL rr_order[%0d]: req_ready_o=%b want %b", c, req_ready_o, oh);
      else n_pass++;
      tick();
    end
    drain();
  endtask

  task automatic test_lock();
    tb_a[0] = 16'sd11; tb_b[0] = 16'sd13;
    tb_a[2] = -16'sd5; tb_b[2] = 16'sd9;
    do_reset();
    mul_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid_i = (c == 0) ? 3'b100 : (c < 5) ? 3'b101 : 3'b001;
      mul_ready_i = (c >= 4);
      @(negedge clk_i);
      if (c < 5) begin
        n_checks++;
        if (mul_a_o !== tb_a[2] || mul_b_o !== tb_b[2] || mul_valid_o !== 1'b1)
          $display("FAIL lock_hold[%0d]: a=%h b=%h v=%b want %h %h 1", c, mul_a_o, mul_b_o,
                   mul_valid_o, tb_a[2], tb_b[2]);
        else n_pass++;
        n_checks++;
        if (req_ready_o !== ((c == 4) ? 3'b100 : 3'b000))
          $display("FAIL lock_ready[%0d]: req_ready_o=%b", c, req_ready_o);
        else n_pass++;
      end else begin
        n_checks++;
        if (req_ready_o !== 3'b001 || mul_a_o !== tb_a[0])
          $display("FAIL lock_release: req_ready_o=%b a=%h want 001 %h", req_ready_o, mul_a_o,
                   tb_a[0]);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    logic [NR-1:0] oh;
    set_rr_ops();
    do_reset();
    req_valid_i = '1;
    for (int c = 0; c < 9; c++) begin
      mul_hold = (c != 6);
      @(negedge clk_i);
      if (c < 4) begin
        oh = '0;
        oh[c % NR] = 1'b1;
        n_checks++;
        if (mul_valid_o !== 1'b1 || req_ready_o !== oh)
          $display("FAIL full_fill[%0d]: v=%b ready=%b want 1 %b", c, mul_valid_o, req_ready_o,
                   oh);
        else n_pass++;
      end else if (c == 7) begin
        n_checks++;
        if (mul_valid_o !== 1'b1 || req_ready_o !== 3'b010)
          $display("FAIL full_refill: v=%b ready=%b want 1 010", mul_valid_o, req_ready_o);
        else n_pass++;
      end else begin
        n_checks++;
        if (mul_valid_o !== 1'b0 || req_ready_o !== 3'b000)
          $display("FAIL full_block[%0d]: v=%b ready=%b want 0 000", c, mul_valid_o,
                   req_ready_o);
        else n_pass++;
      end
      if (c == 6) begin
        n_checks++;
        if (rsp_valid_o !== 3'b001 || mul_ready_o !== 1'b1)
          $display("FAIL full_return: rsp=%b mready=%b want 001 1", rsp_valid_o, mul_ready_o);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [2*DW-1:0] want_c;
    want_c  = -32'sd8638;
    tb_a[1] = -16'sd7;
    tb_b[1] = 16'sd1234;
    mul_lat = 2;
    do_reset();
    rsp_ready_i = 3'b101;
    for (int c = 0; c < 9; c++) begin
      req_valid_i = (c == 0) ? 3'b010 : 3'b000;
      if (c == 7) rsp_ready_i = '1;
      @(negedge clk_i);
      if (c == 0) begin
        n_checks++;
        if (req_ready_o !== 3'b010)
          $display("FAIL bp_issue: req_ready_o=%b want 010", req_ready_o);
        else n_pass++;
      end else if (c >= 2 && c <= 6) begin
        n_checks++;
        if (mul_ready_o !== 1'b0 || rsp_valid_o !== 3'b010 || rsp_c_o !== want_c)
          $display("FAIL bp_hold[%0d]: mready=%b rsp=%b c=%h want 0 010 %h", c, mul_ready_o,
                   rsp_valid_o, rsp_c_o, want_c);
        else n_pass++;
      end else if (c == 7) begin
        n_checks++;
        if (mul_ready_o !== 1'b1 || rsp_valid_o !== 3'b010)
          $display("FAIL bp_release: mready=%b rsp=%b want 1 010", mul_ready_o, rsp_valid_o);
        else n_pass++;
      end else if (c == 8) begin
        n_checks++;
        if (mul_ready_o !== 1'b0 || rsp_valid_o !== 3'b000)
          $display("FAIL bp_popped: mready=%b rsp=%b want 0 000", mul_ready_o, rsp_valid_o);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_pair();
    logic [NR-1:0] oh;
    tb_a[0] = 16'sd21;   tb_b[0] = -16'sd2;
    tb_a[1] = 16'sd0;    tb_b[1] = 16'sd0;
    tb_a[2] = -16'sd300; tb_b[2] = 16'sd250;
    do_reset();
    req_valid_i = 3'b101;
    for (int c = 0; c < 6; c++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
      oh = 3'b001;
`else
      oh = (c % 2 == 0) ? 3'b001 : 3'b100;
`endif
      @(negedge clk_i);
      n_checks++;
      if (req_ready_o !== oh)
        $display("FAIL pair_grant[%0d]: req_ready_o=%b want %b", c, req_ready_o, oh);
      else n_pass++;
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_backpressure();
    test_pair();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter that shares one signed multiplier (ready/valid in, ready/valid out, in-order, arbitrary latency) among NumReq requesters, e.g. the R, G and B fixed-point scaling channels. Selects one requester per cycle, forwards its operands to the multiplier, and records the grant index in a tag FIFO. It then routes each product back to the requester that issued it. It sits between the per-channel datapaths and the single multiplier instance.

## Interface
- DataWidth, 16, operand width; products are 2*DataWidth, signed
- NumReq, 3, number of requesters (2..8)
- TagDepth, 4, max in-flight operations; power of two
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  NumReq  per-requester operand valid
- req_a_i  in  NumReq*DataWidth  operand A, requester k at [k*DataWidth +: DataWidth], signed
- req_b_i  in  NumReq*DataWidth  operand B, same packing, signed
- req_ready_o  out  NumReq  per-requester accept
- mul_valid_o  out  1  operands valid to multiplier
- mul_a_o  out  DataWidth  operand A to multiplier
- mul_b_o  out  DataWidth  operand B to multiplier
- mul_ready_i  in  1  multiplier accepts operands
- mul_valid_i  in  1  product valid from multiplier
- mul_c_i  in  2*DataWidth  product from multiplier
- mul_ready_o  out  1  arbiter accepts product
- rsp_valid_o  out  NumReq  one-hot product valid to owning requester
- rsp_c_o  out  2*DataWidth  product, shared by all requesters
- rsp_ready_i  in  NumReq  per-requester product accept

## Operation
- Issue side:
  - Candidate = first asserted req_valid_i at or after rr_ptr, scanning upward with wrap.
  - Issue allowed only when the tag FIFO is not full.
  - mul_valid_o = (a candidate exists) & !full; mul_a_o/mul_b_o = that candidate's operands.
  - req_ready_o[k] = (k is granted) & mul_ready_i & !full; all other bits 0.
- Grant lock: if mul_valid_o=1 and mul_ready_i=0, lock_q records the grant. The grant stays on the same requester until that handshake, even if rr_ptr would choose another. Lock clears on handshake.
- On an issue handshake to requester k:
  - push k into the tag FIFO;
  - rr_ptr <= (k+1) mod NumReq.
- Return side:
  - head = tag FIFO head.
  - rsp_valid_o[head] = mul_valid_i & !empty; other bits 0.
  - rsp_c_o = mul_c_i unmodified.
  - mul_ready_o = !empty & rsp_ready_i[head].
  - Pop on mul_valid_i & mul_ready_o.
- mul_valid_i while the FIFO is empty is a protocol error: mul_ready_o stays 0, nothing is routed. Assertion flagged in simulation.
- Full: issue blocked even if a pop occurs the same cycle (no push-through).
- Simultaneous push and pop when not full/empty: both take effect; count unchanged.
- Tag FIFO: registered read/write pointers of log2(TagDepth)+1 bits each. Full and empty come from the pointer MSB/LSB compare; pointers wrap naturally.
- Reset mid-operation: FIFO emptied, lock cleared, rr_ptr=0. Products still in flight in the multiplier must be flushed by resetting the multiplier with the same reset_i.

## Timing
- Reset values:
  - rr_ptr=0, lock_q=0, FIFO empty.
  - All outputs 0 while reset_i=1 (mul_valid_o, req_ready_o, rsp_valid_o, mul_ready_o, operand/product buses).
- Arbiter adds zero cycles:
  - Issue path is combinational from req_valid_i/mul_ready_i.
  - Return path is combinational from mul_valid_i/rsp_ready_i.
- Registered state updates on the clk_i rising edge only.
- Throughput: one issue and one return per cycle sustained.
- End-to-end latency = multiplier latency.
- No combinational path from mul_valid_i to req_ready_o.
- No combinational path from req_valid_i to mul_ready_o.

## Configuration
- MUL_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; lowest index wins every cycle.
  - rr_ptr is not implemented.
  - Grant lock retained.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset: hold reset_i 3 cycles with all req_valid_i=1 -> all outputs 0. First post-reset grant goes to requester 0.
- Round-robin: all three requesters valid, mul_ready_i=1, multiplier latency 2 -> issue order 0,1,2,0,1,2. Operands (3,-4), (100,7), (-32768,-32768) return -12, 700, 1073741824 on rsp_valid_o bits 0,1,2 respectively.
- Lock: requester 2 granted, mul_ready_i=0 for 4 cycles while requester 0 asserts valid -> mul_a_o/mul_b_o remain requester 2's operands until the handshake.
- Full: TagDepth=4, multiplier holds mul_valid_i=0 -> exactly 4 issues, then req_ready_o=0 and mul_valid_o=0. After one return, exactly one more issue is accepted on the following cycle.
- Return backpressure: head tag=1, rsp_ready_i[1]=0 for 5 cycles -> mul_ready_o=0, product held, no pop. Release -> pop in the same cycle.
- With MUL_ARB_FIXED_PRIO_EN: requesters 0 and 2 continuously valid -> requester 0 granted every cycle; requester 2 is never granted.
